// File: rtl/usb_buffer_pkg.sv
// Shared types and sizing helpers for the USB endpoint buffer and the RX/TX FSMs.
package usb_buffer_pkg;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_PUSHPOP
  } buf_op_t;

  // Pointer width for a buffer of n entries; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/usb_buffer_wrap_ptr.sv
// Buffer address pointer: wraps DEPTH-1 -> 0, synchronous clear and load.
module usb_buffer_wrap_ptr #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      ptr <= '0;
    else if (clear)  ptr <= '0;
    else if (load)   ptr <= load_val;
    else if (inc)    ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
  end

endmodule

// File: rtl/usb_buffer_pkt_tracker.sv
// Packet-aware pointer/occupancy tracker for the USB endpoint buffer.
// Optional sticky overflow/underflow flags are built only when USB_BUF_ERR_EN is defined.
module usb_buffer_pkt_tracker
  import usb_buffer_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = clog2_min1(DEPTH),
  parameter int CNT_W    = ADDR_W + 1,
  parameter int AFULL_TH = DEPTH - 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic              commit,
  input  logic              rewind,
  output logic [ADDR_W-1:0] wptr,
  output logic [ADDR_W-1:0] rptr,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  avail,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overflow_err,
  output logic              underflow_err
);

  logic              push_ok, pop_ok;
  buf_op_t           op;
  logic [ADDR_W-1:0] mark, mark_next, wptr_inc;
  logic [CNT_W-1:0]  count_next, count_op, avail_next, avail_pop;

  assign push_ok = push & ~full & ~flush & ~rewind;
  assign pop_ok  = pop & ~empty & ~flush;
  assign wptr_inc = (wptr == ADDR_W'(DEPTH - 1)) ? '0 : wptr + 1'b1;

  usb_buffer_wrap_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wptr (
    .clk(clk), .n_rst(n_rst), .clear(flush), .inc(push_ok),
    .load(rewind), .load_val(mark), .ptr(wptr)
  );

  usb_buffer_wrap_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rptr (
    .clk(clk), .n_rst(n_rst), .clear(flush), .inc(pop_ok),
    .load(1'b0), .load_val('0), .ptr(rptr)
  );

  always_comb begin
    op = OP_NONE;
    unique case ({push_ok, pop_ok})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_PUSHPOP;
      default: op = OP_NONE;
    endcase

    count_op = count;
    case (op)
      OP_PUSH: count_op = count + 1'b1;
      OP_POP:  count_op = count - 1'b1;
      default: count_op = count;
    endcase
    avail_pop = pop_ok ? avail - 1'b1 : avail;

    // Rewind drops everything past the commit mark, so total falls back to readable.
    count_next = count_op;
    avail_next = avail_pop;
    mark_next  = mark;
    if (flush) begin
      count_next = '0;
      avail_next = '0;
      mark_next  = '0;
    end else if (rewind) begin
      count_next = avail_pop;
    end else if (commit) begin
      avail_next = count_op;
      mark_next  = push_ok ? wptr_inc : wptr;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mark        <= '0;
      count       <= '0;
      avail       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      mark        <= mark_next;
      count       <= count_next;
      avail       <= avail_next;
      empty       <= (avail_next == '0);
      full        <= (count_next == CNT_W'(DEPTH));
      almost_full <= (int'(count_next) >= AFULL_TH);
    end
  end

`ifdef USB_BUF_ERR_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (flush) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (push & full & ~rewind) overflow_err  <= 1'b1;
      if (pop & empty)           underflow_err <= 1'b1;
    end
  end
`else
  assign overflow_err  = 1'b0;
  assign underflow_err = 1'b0;
`endif

  a_occupancy: assert property (@(posedge clk) disable iff (!n_rst)
    (avail <= count) && (count <= CNT_W'(DEPTH)));
  a_ptr_span: assert property (@(posedge clk) disable iff (!n_rst)
    int'(wptr) == ((int'(rptr) + int'(count)) % DEPTH));

endmodule

// File: tb/tb_usb_buffer_pkt_tracker.sv
// Directed self-checking bench: DEPTH=8 instance for the main scenarios, DEPTH=5 for odd-size wrap.
module tb_usb_buffer_pkt_tracker;

`ifdef USB_BUF_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic a_flush = 0, a_push = 0, a_pop = 0, a_commit = 0, a_rewind = 0;
  logic [2:0] a_wptr, a_rptr;
  logic [3:0] a_count, a_avail;
  logic a_empty, a_full, a_af, a_oerr, a_uerr;

  logic b_flush = 0, b_push = 0, b_pop = 0, b_commit = 0, b_rewind = 0;
  logic [2:0] b_wptr, b_rptr;
  logic [3:0] b_count, b_avail;
  logic b_empty, b_full, b_af, b_oerr, b_uerr;

  usb_buffer_pkt_tracker #(.DEPTH(8), .AFULL_TH(6)) dut_a (
    .clk(clk), .n_rst(n_rst), .flush(a_flush), .push(a_push), .pop(a_pop),
    .commit(a_commit), .rewind(a_rewind), .wptr(a_wptr), .rptr(a_rptr),
    .count(a_count), .avail(a_avail), .empty(a_empty), .full(a_full),
    .almost_full(a_af), .overflow_err(a_oerr), .underflow_err(a_uerr)
  );

  usb_buffer_pkt_tracker #(.DEPTH(5), .AFULL_TH(3)) dut_b (
    .clk(clk), .n_rst(n_rst), .flush(b_flush), .push(b_push), .pop(b_pop),
    .commit(b_commit), .rewind(b_rewind), .wptr(b_wptr), .rptr(b_rptr),
    .count(b_count), .avail(b_avail), .empty(b_empty), .full(b_full),
    .almost_full(b_af), .overflow_err(b_oerr), .underflow_err(b_uerr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock on dut_a with the given controls held across the edge; sample 1ns after.
  task automatic cyc(input logic pu, input logic po, input logic cm, input logic rw, input logic fl);
    a_push = pu; a_pop = po; a_commit = cm; a_rewind = rw; a_flush = fl;
    @(posedge clk); #1;
    a_push = 0; a_pop = 0; a_commit = 0; a_rewind = 0; a_flush = 0;
  endtask

  task automatic chk_a(input string tag, input int w, input int r, input int c, input int av,
                       input logic e, input logic f, input logic af, input logic oe, input logic ue);
    chk({tag, ".wptr"},  32'(a_wptr),  32'(w));
    chk({tag, ".rptr"},  32'(a_rptr),  32'(r));
    chk({tag, ".count"}, 32'(a_count), 32'(c));
    chk({tag, ".avail"}, 32'(a_avail), 32'(av));
    chk({tag, ".empty"}, 32'(a_empty), 32'(e));
    chk({tag, ".full"},  32'(a_full),  32'(f));
    chk({tag, ".afull"}, 32'(a_af),    32'(af));
    chk({tag, ".oerr"},  32'(a_oerr),  32'(oe));
    chk({tag, ".uerr"},  32'(a_uerr),  32'(ue));
  endtask

  initial begin
    #12;
    chk_a("reset", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("reset_b.empty", 32'(b_empty), 32'd1);
    n_rst = 1;

    // 1: fill to full with commit each push; 9th push dropped
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 0, 1, 0, 0);
      chk($sformatf("fill%0d.count", k), 32'(a_count), 32'(k));
      chk($sformatf("fill%0d.avail", k), 32'(a_avail), 32'(k));
      chk($sformatf("fill%0d.afull", k), 32'(a_af), (k >= 6) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d.full", k),  32'(a_full), (k == 8) ? 32'd1 : 32'd0);
    end
    cyc(1, 0, 1, 0, 0);
    chk_a("push_full", 0, 0, 8, 8, 0, 1, 1, ERR, 0);
    cyc(0, 0, 0, 0, 1);
    chk_a("flush1", 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // 2: fill 5, commit, drain, then push 5 across the wrap
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0, 0);
    chk_a("fill5_uncommitted", 5, 0, 5, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk_a("commit5", 5, 0, 5, 5, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 1, 0, 0, 0);
      chk($sformatf("drain%0d.avail", k), 32'(a_avail), 32'(5 - k));
    end
    chk_a("drained", 5, 5, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0, 0);
    chk_a("wrap_push", 2, 5, 5, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);

    // 3: commit 3, push 4 more, rewind to the mark, drain
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    chk_a("pkt3", 3, 0, 3, 3, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 0);
    chk_a("pkt3_plus4", 7, 0, 7, 3, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk_a("rewind", 3, 0, 3, 3, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 0);
    chk_a("rewind_drain", 3, 3, 0, 0, 1, 0, 0, 0, 0);

    // 4: steady push+pop+commit at count=4 for 20 cycles
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    chk_a("steady_start", 7, 3, 4, 4, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      cyc(1, 1, 1, 0, 0);
      chk($sformatf("steady%0d.count", k), 32'(a_count), 32'd4);
      chk($sformatf("steady%0d.wptr", k),  32'(a_wptr), 32'((7 + k) % 8));
      chk($sformatf("steady%0d.rptr", k),  32'(a_rptr), 32'((3 + k) % 8));
      chk($sformatf("steady%0d.flags", k), 32'({a_empty, a_full, a_af}), 32'd0);
    end
    cyc(0, 0, 0, 0, 1);

    // 5: pop against uncommitted-only data is refused
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk_a("pop_uncommitted", 2, 0, 2, 0, 1, 0, 0, 0, ERR);
    cyc(0, 0, 0, 0, 1);
    chk_a("flush_errs", 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // 6: push+commit+rewind -> rewind wins; flush+push -> flush wins
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk_a("pre_rewind", 3, 0, 3, 2, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 0);
    chk_a("rewind_wins", 2, 0, 2, 2, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 1);
    chk_a("flush_wins", 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // async reset mid-packet
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    #2 n_rst = 0;
    #1 chk_a("async_reset", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    #1 n_rst = 1;

    // 7: DEPTH=5 wrap with balanced push/pop
    b_push = 1;
    @(posedge clk); #1;
    b_commit = 1;
    @(posedge clk); #1;
    chk("b_start.count", 32'(b_count), 32'd2);
    chk("b_start.wptr",  32'(b_wptr),  32'd2);
    b_pop = 1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk($sformatf("b%0d.wptr", k),  32'(b_wptr),  32'((2 + k) % 5));
      chk($sformatf("b%0d.rptr", k),  32'(b_rptr),  32'(k % 5));
      chk($sformatf("b%0d.count", k), 32'(b_count), 32'd2);
    end
    b_push = 0; b_pop = 0; b_commit = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
